// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches and buffers responses for decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_stall,
   output logic            id_valid,
   output logic [31:0]     id_instr,
   output logic [XLEN-1:0] id_pc,
`ifdef FETCH_PERF_EN
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall,
`endif
   output logic [4:0]      id_opcode
);

   localparam int              CW      = $clog2(DEPTH) + 1;
   localparam int              AW      = $clog2(DEPTH);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [31:0]     NOP     = 32'h0000_0013;

   logic [XLEN-1:0] pc;
   logic [CW-1:0]   outstanding, drop, fifo_count;
   logic [AW-1:0]   rd_ptr, wr_ptr, tag_rd, tag_wr;
   logic [XLEN-1:0] fifo_pc    [DEPTH];
   logic [31:0]     fifo_instr [DEPTH];
   logic [XLEN-1:0] tag_pc     [DEPTH];
   logic [CW:0]     in_use;
   logic            credit, accept, resp_keep, resp_drop, pop;
   logic [XLEN-1:0] redirect_target;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Buffered plus in-flight words may never exceed DEPTH, so a response always has a slot.
   assign in_use          = {1'b0, fifo_count} + {1'b0, outstanding};
   assign credit          = in_use < {1'b0, DEPTH_C};
   assign imem_req_valid  = !rst && !redirect_valid && credit;
   assign imem_req_addr   = pc;
   assign accept          = imem_req_valid && imem_req_ready;
   assign resp_keep       = imem_resp_valid && (drop == '0);
   assign resp_drop       = imem_resp_valid && (drop != '0);
   assign id_valid        = fifo_count != '0;
   assign pop             = id_valid && !id_stall && !redirect_valid;
   assign redirect_target = redirect_pc & ~XLEN'(3);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
         fifo_count  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
      end else if (redirect_valid) begin
         // Every word still owed by memory becomes wrong-path; one arriving now is consumed here.
         pc          <= redirect_target;
         outstanding <= '0;
         drop        <= drop + outstanding + CW'(accept) - CW'(imem_resp_valid);
         fifo_count  <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
      end else begin
         if (accept) begin
            pc     <= pc + XLEN'(4);
            tag_wr <= inc(tag_wr);
         end
         if (resp_drop) drop <= drop - 1'b1;
         if (resp_keep) begin
            wr_ptr <= inc(wr_ptr);
            tag_rd <= inc(tag_rd);
         end
         if (pop) rd_ptr <= inc(rd_ptr);
         outstanding <= outstanding + CW'(accept) - CW'(resp_keep);
         fifo_count  <= fifo_count + CW'(resp_keep) - CW'(pop);
      end
   end

   // Payload storage; validity is tracked entirely by the counters and pointers above.
   always_ff @(posedge clk) begin
      if (accept) tag_pc[tag_wr] <= pc;
      if (resp_keep) begin
         fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
         fifo_instr[wr_ptr] <= imem_resp_data;
      end
   end

   assign id_instr  = id_valid ? fifo_instr[rd_ptr] : NOP;
   assign id_pc     = id_valid ? fifo_pc[rd_ptr] : '0;
   assign id_opcode = id_instr[6:2];

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop)                  perf_fetched <= perf_fetched + 32'd1;
         if (id_valid && id_stall) perf_stall   <= perf_stall + 32'd1;
      end
   end
`endif

   fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(resp_keep && !pop && !redirect_valid && fifo_count == DEPTH_C));

endmodule
